// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit subtractor controller: one full-subtractor step per clock, LSB first.
// Optional macro SUB_OVERFLOW_EN registers the signed overflow flag on outv.
module serial_subtractor_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] inA,
   input  logic [WIDTH-1:0] inB,
   input  logic             inb,
   output logic [WIDTH-1:0] outD,
   output logic             outb,
   output logic             outv,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] result;
   logic             borrow;
   logic [CW-1:0]    cnt;

   logic bit_a;
   logic bit_b;
   logic diff_bit;
   logic borrow_next;
   logic last_bit;

   assign bit_a       = op_a[0];
   assign bit_b       = op_b[0];
   assign diff_bit    = bit_a ^ bit_b ^ borrow;
   assign borrow_next = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & borrow);
   assign last_bit    = (state == RUN) && (cnt == LAST);

   // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         op_a   <= '0;
         op_b   <= '0;
         result <= '0;
         borrow <= 1'b0;
         cnt    <= '0;
         outD   <= '0;
         outb   <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  op_a   <= inA;
                  op_b   <= inB;
                  borrow <= inb;
                  result <= '0;
                  cnt    <= '0;
                  state  <= RUN;
               end else begin
                  state  <= IDLE;
               end
            end
            RUN: begin
               op_a   <= {1'b0, op_a[WIDTH-1:1]};
               op_b   <= {1'b0, op_b[WIDTH-1:1]};
               result <= {diff_bit, result[WIDTH-1:1]};
               borrow <= borrow_next;
               cnt    <= cnt + CW'(1);
               if (last_bit) begin
                  outD  <= {diff_bit, result[WIDTH-1:1]};
                  outb  <= borrow_next;
                  state <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SUB_OVERFLOW_EN
   // On the last bit the borrow register holds the borrow into the MSB.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outv <= 1'b0;
      end else if (last_bit) begin
         outv <= borrow ^ borrow_next;
      end
   end
`else
   assign outv = 1'b0;
`endif

   assign busy = (state == RUN);
   assign done = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Directed self-checking bench for serial_subtractor_ctrl (WIDTH = 8).
module tb_serial_subtractor_ctrl;

   localparam int WIDTH = 8;
`ifdef SUB_OVERFLOW_EN
   localparam logic OV = 1'b1;
`else
   localparam logic OV = 1'b0;
`endif

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_bi;
   logic [WIDTH-1:0] out_d;
   logic             out_b;
   logic             out_v;
   logic             busy;
   logic             done;

   int n_checks = 0;
   int n_pass   = 0;

   serial_subtractor_ctrl #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .inA   (in_a),
      .inB   (in_b),
      .inb   (in_bi),
      .outD  (out_d),
      .outb  (out_b),
      .outv  (out_v),
      .busy  (busy),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   // Issue a one-cycle start at the next edge; returns at the negedge after acceptance.
   task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic bi);
      @(negedge clk);
      in_a  = a;
      in_b  = b;
      in_bi = bi;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Waits (bounded) for done, sampling on negedges; reports how many negedges it took.
   task automatic wait_done(output int cycles);
      cycles = 0;
      while (!done && cycles < 40) begin
         @(negedge clk);
         cycles++;
      end
   endtask

   task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b, input logic bi,
                         input logic [7:0] ed, input logic eb, input logic ev);
      int busy_cnt;
      int extra_done;
      issue(a, b, bi);
      busy_cnt   = 0;
      extra_done = 0;
      for (int i = 0; i < WIDTH; i++) begin
         if (busy) busy_cnt++;
         if (done) extra_done++;
         @(negedge clk);
      end
      check({tag, " busy_cycles"}, busy_cnt, WIDTH);
      check({tag, " done_early"}, extra_done, 0);
      check({tag, " done"}, {31'd0, done}, 1);
      check({tag, " busy_in_done"}, {31'd0, busy}, 0);
      check({tag, " outD"}, {24'd0, out_d}, {24'd0, ed});
      check({tag, " outb"}, {31'd0, out_b}, {31'd0, eb});
      check({tag, " outv"}, {31'd0, out_v}, {31'd0, ev});
      @(negedge clk);
      check({tag, " done_pulse"}, {31'd0, done}, 0);
   endtask

   initial begin
      int cyc;
      int seen_done;
      rst_n = 1'b0;
      start = 1'b0;
      in_a  = '0;
      in_b  = '0;
      in_bi = 1'b0;
      #23;
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check("reset outD", {24'd0, out_d}, 0);
      check("reset outb", {31'd0, out_b}, 0);
      check("reset outv", {31'd0, out_v}, 0);
      check("reset busy", {31'd0, busy}, 0);
      check("reset done", {31'd0, done}, 0);

      run_op("5-3",   8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
      run_op("3-5",   8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
      run_op("0-0-1", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
      run_op("80-01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, OV);
      run_op("7F-FF", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, OV);

      // start pulsed mid-RUN must be ignored
      issue(8'h10, 8'h01, 1'b0);
      @(negedge clk);
      in_a  = 8'hAA;
      in_b  = 8'h55;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(cyc);
      check("midrun done_latency", cyc, WIDTH - 2);
      check("midrun done", {31'd0, done}, 1);
      check("midrun outD", {24'd0, out_d}, 32'h0F);
      check("midrun outb", {31'd0, out_b}, 0);

      // back-to-back: start held through DONE
      in_a  = 8'h20;
      in_b  = 8'h20;
      in_bi = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("b2b busy", {31'd0, busy}, 1);
      check("b2b outD_hold", {24'd0, out_d}, 32'h0F);
      wait_done(cyc);
      check("b2b done_latency", cyc + 1, WIDTH + 1);
      check("b2b outD", {24'd0, out_d}, 0);
      check("b2b outb", {31'd0, out_b}, 0);

      // populate outputs with nonzero values, then abort an operation with reset
      run_op("pre_rst", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
      issue(8'hFF, 8'h01, 1'b0);
      repeat (3) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst outD", {24'd0, out_d}, 0);
      check("async_rst outb", {31'd0, out_b}, 0);
      check("async_rst outv", {31'd0, out_v}, 0);
      check("async_rst busy", {31'd0, busy}, 0);
      check("async_rst done", {31'd0, done}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      seen_done = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done || busy) seen_done++;
      end
      check("post_rst idle", seen_done, 0);
      run_op("9-4", 8'h09, 8'h04, 1'b0, 8'h05, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
